// File: rtl/fa3_pkg.sv
// fa3_pkg: shared chunk width and FSM state encoding for the serial adder
package fa3_pkg;
  localparam int CHUNK_W = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/add3_slice.sv
// add3_slice: combinational 3-bit full-adder slice reused for every chunk
module add3_slice
  import fa3_pkg::*;
(
  input  logic [CHUNK_W-1:0] a3,
  input  logic [CHUNK_W-1:0] b3,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s3,
  output logic               co
);
  assign {co, s3} = {1'b0, a3} + {1'b0, b3} + {{CHUNK_W{1'b0}}, ci};
endmodule

// File: rtl/fa3_serial_add_ctrl.sv
// fa3_serial_add_ctrl: wide adder that reuses one 3-bit slice over NCHUNK cycles, LSB chunk first
module fa3_serial_add_ctrl
  import fa3_pkg::*;
#(
  parameter int NCHUNK = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHUNK_W*NCHUNK-1:0] a,
  input  logic [CHUNK_W*NCHUNK-1:0] b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK_W*NCHUNK-1:0] sum,
  output logic                      cout,
  output logic                      busy
);
  localparam int W  = CHUNK_W * NCHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int IW = $clog2(W);
  state_t             state;
  logic [W-1:0]       a_r, b_r, sum_r;
  logic               carry_r;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      base;
  logic [CHUNK_W-1:0] s3;
  logic               co;
  logic               last;
  assign base      = IW'(CHUNK_W * int'(cnt));
  assign last      = cnt == CW'(NCHUNK - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == RUN;
  assign sum       = sum_r;
  assign cout      = carry_r;
  add3_slice u_slice (
    .a3(a_r[base +: CHUNK_W]),
    .b3(b_r[base +: CHUNK_W]),
    .ci(carry_r),
    .s3(s3),
    .co(co)
  );
  // accept operands, ripple one chunk per RUN cycle through carry_r, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r     <= a;
          b_r     <= b;
          carry_r <= cin;
          cnt     <= '0;
          state   <= RUN;
        end
        RUN: begin
          sum_r[base +: CHUNK_W] <= s3;
          carry_r                <= co;
          cnt                    <= last ? '0 : cnt + 1'b1;
          if (last) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
